mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 7 +
 rtl/rr_pick2.sv | 10 +
 rtl/mem_arbiter.sv | 92 +++++++++
 tb/tb_mem_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM states and burst geometry for the memory arbiter.
package mem_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, BURST, FINISH} state_t;
    localparam int BEATS = 4;
    localparam int OFF_W = 4;
    localparam int STRIDE = 4;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin pick; on a tie the requester not granted last wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       valid
);
    assign valid  = |req;
    assign winner = (&req) ? ~last : req[1];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants one of two requesters a non-abortable block burst to main memory.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int BEATS  = mem_arbiter_pkg::BEATS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    output logic              grant0,
    output logic              grant1,
    output logic              ack0,
    output logic              ack1,
    output logic              done0,
    output logic              done1,
    output logic [1:0]        beat,
    output logic [31:0]       rdata,
    output logic              mem_req,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_done,
    input  logic [31:0]       mem_rdata
);
    state_t            state, state_d;
    logic [1:0]        beat_q;
    logic              owner, we_r, last, winner, valid, busy, fin, last_beat;
    logic [ADDR_W-1:0] addr_r;

    rr_pick2 u_pick (
        .req    ({req1, req0}),
        .last   (last),
        .winner (winner),
        .valid  (valid)
    );

    always_ff @(posedge clock)
        state <= reset ? IDLE : state_d;

    always_comb begin
        state_d = state;
        state_d = (state == IDLE)  ? (valid ? BURST : IDLE) :
                  (state == BURST) ? ((mem_done && last_beat) ? FINISH : BURST) : IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            beat_q <= '0;
            last   <= 1'b1;
            owner  <= 1'b0;
            we_r   <= 1'b0;
            addr_r <= '0;
        end else begin
            // The other requester's inputs are only looked at here, in IDLE.
            if (state == IDLE && valid) begin
                owner  <= winner;
                we_r   <= winner ? we1 : we0;
                addr_r <= winner ? addr1 : addr0;
                beat_q <= '0;
            end
            if (state == BURST && mem_done)
                beat_q <= beat_q + 2'd1;
            if (state == FINISH)
                last <= owner;
        end
    end

    // Reset gates every output so nothing leaks during the reset cycle itself.
    assign busy      = state == BURST && !reset;
    assign fin       = state == FINISH && !reset;
    assign last_beat = beat_q == 2'(BEATS - 1);
    assign grant0    = busy && !owner;
    assign grant1    = busy && owner;
    assign ack0      = grant0 && mem_done;
    assign ack1      = grant1 && mem_done;
    assign done0     = fin && !owner;
    assign done1     = fin && owner;
    assign beat      = reset ? 2'd0 : beat_q;
    assign rdata     = (ack0 || ack1) ? mem_rdata : '0;
    assign mem_req   = busy;
    assign mem_write = busy && we_r;
    assign mem_addr  = busy ? {addr_r[ADDR_W-1:OFF_W], OFF_W'(0)} + ADDR_W'(beat_q) * ADDR_W'(STRIDE) : '0;
    assign mem_wdata = busy ? (owner ? wdata1 : wdata0) : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed burst table plus hand-written tie, reset and stray-pulse sequences.
module tb_mem_arbiter;
    logic        clock = 0, reset = 1;
    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [9:0]  addr0 = 0, addr1 = 0;
    logic [31:0] wdata0 = 0, wdata1 = 0;
    logic        grant0, grant1, ack0, ack1, done0, done1;
    logic [1:0]  beat;
    logic [31:0] rdata;
    logic        mem_req, mem_write;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_done = 0;
    logic [31:0] mem_rdata = 0;
    int          checks = 0, errors = 0;

    typedef struct {
        bit          id;
        bit          we;
        logic [9:0]  addr;
        logic [31:0] base;
        logic [9:0]  exp_addr;
    } vec_t;
    vec_t vecs[4];

    mem_arbiter dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .grant0(grant0), .grant1(grant1), .ack0(ack0), .ack1(ack1),
        .done0(done0), .done1(done1), .beat(beat), .rdata(rdata),
        .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input bit id, input logic v);
        if (id) req1 = v;
        else req0 = v;
    endtask

    task automatic check_quiet(input string name);
        check({name, "_grant"}, {grant1, grant0}, 0);
        check({name, "_ack"}, {ack1, ack0}, 0);
        check({name, "_done"}, {done1, done0}, 0);
        check({name, "_memreq"}, {mem_req, mem_write}, 0);
        check({name, "_addr"}, mem_addr, 0);
        check({name, "_wdata"}, mem_wdata, 0);
        check({name, "_rdata"}, rdata, 0);
        check({name, "_beat"}, beat, 0);
    endtask

    // Called on the first BURST cycle; returns one cycle into the following IDLE.
    task automatic serve(input bit id, input bit we, input logic [9:0] exp_addr,
                         input logic [31:0] base, input bit drop_early);
        for (int b = 0; b < 4; b++) begin
            logic [31:0] w;
            w = base * 32'(b + 1);
            if (b % 2 == 1) begin
                mem_done = 0;
                #1;
                check("wait_ack", {ack1, ack0}, 0);
                check("wait_beat", beat, b);
                check("wait_grant", {grant1, grant0}, id ? 2 : 1);
                step;
            end
            if (id) wdata1 = w;
            else wdata0 = w;
            mem_rdata = w;
            mem_done = 1;
            #1;
            check("grant", {grant1, grant0}, id ? 2 : 1);
            check("mem_req", mem_req, 1);
            check("mem_write", mem_write, we);
            check("mem_addr", mem_addr, exp_addr + 10'(4 * b));
            check("beat", beat, b);
            check("ack", {ack1, ack0}, id ? 2 : 1);
            check("rdata", rdata, w);
            check("done_mid", {done1, done0}, 0);
            if (we) check("mem_wdata", mem_wdata, w);
            step;
            mem_done = 0;
            if (drop_early && b == 0) set_req(id, 0);
        end
        #1;
        check("fin_done", {done1, done0}, id ? 2 : 1);
        check("fin_grant", {grant1, grant0}, 0);
        check("fin_mem_req", mem_req, 0);
        check("fin_ack", {ack1, ack0}, 0);
        set_req(id, 0);
        step;
        check("post_done", {done1, done0}, 0);
    endtask

    task automatic run_burst(input vec_t v);
        if (v.id) begin we1 = v.we; addr1 = v.addr; end
        else begin we0 = v.we; addr0 = v.addr; end
        set_req(v.id, 1);
        #1;
        check("idle_grant", {grant1, grant0}, 0);
        check("idle_mem_req", mem_req, 0);
        step;
        serve(v.id, v.we, v.exp_addr, v.base, 0);
    endtask

    initial begin
        vecs[0] = '{id: 0, we: 0, addr: 10'h2A4, base: 32'h11,        exp_addr: 10'h2A0};
        vecs[1] = '{id: 1, we: 1, addr: 10'h3F0, base: 32'h1000_0001, exp_addr: 10'h3F0};
        vecs[2] = '{id: 0, we: 1, addr: 10'h01F, base: 32'h5,         exp_addr: 10'h010};
        vecs[3] = '{id: 1, we: 0, addr: 10'h155, base: 32'hA0A0,      exp_addr: 10'h150};

        mem_done = 1;
        step;
        step;
        check_quiet("in_reset");
        reset = 0;
        mem_done = 0;
        step;
        check_quiet("after_reset");

        // Tie right after reset: requester 0 first, requester 1 two cycles after done0.
        req0 = 1; we0 = 0; addr0 = 10'h2A4;
        req1 = 1; we1 = 1; addr1 = 10'h3F0;
        #1;
        check("tie_idle_grant", {grant1, grant0}, 0);
        step;
        serve(0, 0, 10'h2A0, 32'h11, 0);
        check("tie_gap_grant", {grant1, grant0}, 0);
        check("tie_gap_memreq", mem_req, 0);
        step;
        serve(1, 1, 10'h3F0, 32'h2, 0);

        for (int i = 0; i < 4; i++) run_burst(vecs[i]);

        // Reset after the second mem_done abandons the burst without a done pulse.
        req0 = 1; we0 = 1; addr0 = 10'h100;
        step;
        for (int b = 0; b < 2; b++) begin
            mem_done = 1;
            step;
            mem_done = 0;
        end
        #1;
        check("pre_rst_beat", beat, 2);
        check("pre_rst_grant", {grant1, grant0}, 1);
        reset = 1;
        req0 = 0;
        #1;
        check_quiet("rst_mid");
        step;
        reset = 0;
        #1;
        check_quiet("rst_after");
        step;
        check_quiet("rst_idle");
        run_burst('{id: 0, we: 0, addr: 10'h100, base: 32'h7, exp_addr: 10'h100});

        // Stray mem_done in IDLE, then requester 0 drops req after its first beat.
        mem_done = 1;
        mem_rdata = 32'hDEAD;
        #1;
        check_quiet("stray");
        step;
        mem_done = 0;
        #1;
        check_quiet("stray_after");
        req0 = 1; we0 = 0; addr0 = 10'h0C8;
        step;
        serve(0, 0, 10'h0C0, 32'h3, 1);
        step;
        check_quiet("final_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
